// File: rtl/fpga_test_step_div_pkg.sv
// Shared types and constants for the step-model sequential signed divider.
package fpga_test_step_div_pkg;

    localparam int din0_WIDTH = 45;
    localparam int din1_WIDTH = 22;
    localparam int dout_WIDTH = 23;

    localparam int ITER  = din0_WIDTH;
    localparam int CNT_W = $clog2(ITER);

    localparam int QMAX = (1 << (dout_WIDTH - 1)) - 1;
    localparam int QMIN = -(1 << (dout_WIDTH - 1));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Magnitude of a two's complement dividend; -2^44 maps to 2^44 unsigned.
    function automatic logic [din0_WIDTH-1:0] abs_mag(input logic [din0_WIDTH-1:0] v);
        return v[din0_WIDTH-1] ? -v : v;
    endfunction

endpackage

// File: rtl/fpga_test_step_div_core.sv
// Radix-2 restoring shift-subtract core: one quotient bit per step.
// Latency: ITER step cycles after load. No backpressure: steps whenever step is high.
// Flow: load captures operands and clears state; last flags the final iteration.
module fpga_test_step_div_core
    import fpga_test_step_div_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  step,
    input  logic [din0_WIDTH-1:0] dvd_mag,
    input  logic [din1_WIDTH-1:0] dvs,
    output logic [din0_WIDTH-1:0] qmag,
    output logic [dout_WIDTH-1:0] rmag,
    output logic                  last
);

    logic [din0_WIDTH-1:0] dvd_sh;
    logic [din1_WIDTH-1:0] dvs_r;
    logic [dout_WIDTH-1:0] pr;
    logic [din0_WIDTH-1:0] qsh;
    logic [CNT_W-1:0]      cnt;

    logic [dout_WIDTH-1:0] shifted;
    logic [dout_WIDTH-1:0] diff;
    logic                  ge;

    // Partial remainder stays below the divisor, so bit 22 is always free for the shift.
    assign shifted = {pr[dout_WIDTH-2:0], dvd_sh[din0_WIDTH-1]};
    assign ge      = shifted >= {1'b0, dvs_r};
    assign diff    = shifted - {1'b0, dvs_r};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dvd_sh <= '0;
            dvs_r  <= '0;
            pr     <= '0;
            qsh    <= '0;
            cnt    <= '0;
        end else if (load) begin
            dvd_sh <= dvd_mag;
            dvs_r  <= dvs;
            pr     <= '0;
            qsh    <= '0;
            cnt    <= '0;
        end else if (step) begin
            dvd_sh <= dvd_sh << 1;
            pr     <= ge ? diff : shifted;
            qsh    <= {qsh[din0_WIDTH-2:0], ge};
            cnt    <= cnt + CNT_W'(1);
        end
    end

    assign qmag = qsh;
    assign rmag = pr;
    assign last = (cnt == CNT_W'(ITER - 1));

endmodule

// File: rtl/fpga_test_step_sdiv_45s_22ns_23_seq.sv
// Signed 45-bit by unsigned 22-bit sequential divider, saturated 23-bit quotient/remainder.
// Latency: ap_done in the cycle after edge 46 (accept = edge 0); issue interval 48 cycles.
// Backpressure: ap_start sampled only in IDLE; macro FPGA_TEST_STEP_SDIV_REM_EN builds rem.
module fpga_test_step_sdiv_45s_22ns_23_seq
    import fpga_test_step_div_pkg::*;
(
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ap_start,
    output logic                  ap_done,
    output logic                  ap_idle,
    output logic                  ap_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic [dout_WIDTH-1:0] quot,
    output logic [dout_WIDTH-1:0] rem,
    output logic                  ovf,
    output logic                  dz
);

    localparam logic signed [din0_WIDTH:0] QMAX_EXT = (din0_WIDTH + 1)'(QMAX);
    localparam logic signed [din0_WIDTH:0] QMIN_EXT = (din0_WIDTH + 1)'(QMIN);

    state_t                       state;
    state_t                       state_next;
    logic                         accept;
    logic                         last;
    logic                         neg;
    logic                         div_zero;
    logic [din0_WIDTH-1:0]        qmag;
    logic [dout_WIDTH-1:0]        rmag;
    logic signed [din0_WIDTH:0]   q_signed;
    logic [dout_WIDTH-1:0]        quot_next;
    logic                         ovf_next;

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) state <= IDLE;
        else           state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: if (ap_start) begin
                state_next = CALC;
                accept     = 1'b1;
            end
            CALC:    if (last) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign ap_idle  = (state == IDLE);
    assign ap_done  = (state == DONE);
    assign ap_ready = ap_done;

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            neg      <= 1'b0;
            div_zero <= 1'b0;
        end else if (accept) begin
            neg      <= din0[din0_WIDTH-1];
            div_zero <= (din1 == '0);
        end
    end

    fpga_test_step_div_core u_core (
        .clk     (ap_clk),
        .rst_n   (ap_rst_n),
        .load    (accept),
        .step    (state == CALC),
        .dvd_mag (abs_mag(din0)),
        .dvs     (din1),
        .qmag    (qmag),
        .rmag    (rmag),
        .last    (last)
    );

    always_comb begin
        q_signed  = neg ? -signed'({1'b0, qmag}) : signed'({1'b0, qmag});
        quot_next = q_signed[dout_WIDTH-1:0];
        ovf_next  = 1'b0;
        // A zero divisor overrides whatever the core produced.
        if (div_zero) begin
            quot_next = neg ? dout_WIDTH'(QMIN) : dout_WIDTH'(QMAX);
        end else if (q_signed > QMAX_EXT) begin
            quot_next = dout_WIDTH'(QMAX);
            ovf_next  = 1'b1;
        end else if (q_signed < QMIN_EXT) begin
            quot_next = dout_WIDTH'(QMIN);
            ovf_next  = 1'b1;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            quot <= '0;
            ovf  <= 1'b0;
            dz   <= 1'b0;
        end else if (state == FIX) begin
            quot <= quot_next;
            ovf  <= ovf_next;
            dz   <= div_zero;
        end
    end

`ifdef FPGA_TEST_STEP_SDIV_REM_EN
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n)           rem <= '0;
        else if (state == FIX)   rem <= div_zero ? '0 : (neg ? -rmag : rmag);
    end
`else
    logic unused_rmag;
    assign unused_rmag = ^rmag;
    assign rem         = '0;
`endif

endmodule

// File: doc/fpga_test_step_sdiv_45s_22ns_23_seq.md
# fpga_test_step_sdiv_45s_22ns_23_seq

Sequential signed-by-unsigned divider that inverts the step model's 23s×22ns→45 product: it takes a 45-bit signed dividend and a 22-bit unsigned divisor and returns a saturated 23-bit signed quotient plus a 23-bit signed remainder. It sits in the FIL step datapath wherever a scaled product must be brought back to operand range. It uses the ap_ctrl_hs block handshake and a radix-2 restoring shift-subtract core, one quotient bit per cycle.

## Interface
- din0_WIDTH, 45, dividend width (signed)
- din1_WIDTH, 22, divisor width (unsigned)
- dout_WIDTH, 23, quotient and remainder width (signed)
- ap_clk  in  1  clock; all state changes on the rising edge
- ap_rst_n  in  1  synchronous, active-low reset
- ap_start  in  1  request; sampled only in IDLE
- ap_done  out  1  one-cycle pulse when results are valid
- ap_idle  out  1  high while in IDLE
- ap_ready  out  1  equals ap_done; operands may change
- din0  in  45  dividend, two's complement
- din1  in  22  divisor, unsigned
- quot  out  23  quotient, truncated toward zero, saturated
- rem  out  23  remainder, sign of dividend, |rem| < din1
- ovf  out  1  quotient saturated
- dz  out  1  divisor was zero

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE with ap_start=1 (accept edge): capture |din0| (45-bit unsigned), sign(din0), din1; clear partial remainder and counter; go to CALC.
- CALC: each edge shifts one magnitude bit into the partial remainder (23 bits); if ≥ divisor, subtract and set quotient bit. After 45 iterations (counter 0..44), go to FIX.
- FIX: apply signs. q = sign ? −qmag : qmag; r = sign ? −rmag : rmag.
- Saturation: if q > 4194303, quot=4194303, ovf=1. If q < −4194304, quot=−4194304, ovf=1. −4194304 itself is not an overflow.
- Divide by zero: dz=1, ovf=0, rem=0, quot=4194303 for dividend ≥0 and −4194304 for dividend <0. Latency is unchanged. The core runs, but its result is discarded.
- Results are registered in FIX and go to DONE.
- DONE: ap_done=ap_ready=1 for exactly one cycle, then go unconditionally to IDLE.
- quot/rem/ovf/dz hold their values until the FIX of the next operation.
- Operand changes after the accept edge are ignored.

## Timing
- Reset values (ap_rst_n=0 at an edge, in any state, including mid-CALC): state=IDLE, ap_idle=1, ap_done=ap_ready=0, quot=rem=0, ovf=dz=0. The in-flight operation is dropped with no ap_done.
- ap_idle is decoded combinationally from state. It drops in the cycle after the accept edge.
- Latency: accept edge = edge 0; CALC edges 1..45; FIX edge 46. ap_done is high during the cycle following edge 46, i.e. din0_WIDTH+1 edges after accept.
- Issue interval with ap_start held high: 48 cycles. The edge after DONE returns to IDLE, and the next edge accepts.
- ap_start during CALC/FIX/DONE has no effect.

## Configuration
- FPGA_TEST_STEP_SDIV_REM_EN defined: remainder sign-fix and rem register are built, and rem behaves as specified.
- FPGA_TEST_STEP_SDIV_REM_EN undefined: the rem port is kept and tied to 0, and the remainder output logic is removed. quot, ovf, dz and timing are identical in both builds.

## Structure
- Package fpga_test_step_div_pkg holds:
  - state enum (IDLE, CALC, FIX, DONE);
  - width localparams;
  - ITER = din0_WIDTH;
  - QMAX = 2^22−1 and QMIN = −2^22.
- Sub-module fpga_test_step_div_core holds the shift-subtract datapath: partial remainder, quotient magnitude shift register, iteration counter. The top holds the FSM, sign handling, saturation and output registers.

## Test plan
- din0=1000, din1=7 → quot=142, rem=6, ovf=0, dz=0; ap_done high only in the cycle after edge 46.
- din0=−1000, din1=7 → quot=−142, rem=−6. din0=−4194304, din1=1 → quot=−4194304, ovf=0.
- din0=2^40, din1=1 → quot=4194303, rem=0, ovf=1. din0=−2^44, din1=1 → quot=−4194304, ovf=1.
- din1=0: with din0=5 → quot=4194303, rem=0, dz=1. With din0=−5 → quot=−4194304, dz=1, same latency.
- Reset asserted at edge 20 of CALC → next cycle all outputs at reset values, ap_idle=1, no ap_done. A following 1000/7 completes correctly.
- ap_start held high with operands changed every cycle → accepts exactly every 48 cycles. Results match the operands sampled on each accept edge. Build without FPGA_TEST_STEP_SDIV_REM_EN → rem=0 always, quot unchanged.
